// File: rtl/axis_rr_arbiter.sv
// Four-source AXI-Stream round-robin arbiter with a registered output stage.
// Define AXIS_ARB_PACKET_LOCK_EN to hold the grant on one source until its s_last beat.
module axis_rr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        s_valid,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC-1:0]        s_last,
  output logic [NUM_SRC-1:0]        s_ready,
  output logic                      m_valid,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_last,
  output logic [1:0]                m_src,
  input  logic                      m_ready
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_lock_src;
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_last;
  logic [1:0]          r_m_src;

  logic                w_accept;
  logic [2*NUM_SRC-1:0] w_dbl;
  logic [NUM_SRC-1:0]  w_rot;
  logic [1:0]          w_off;
  logic                w_any;
  logic [1:0]          w_sel;
  logic [NUM_SRC-1:0]  w_grant;
  logic                w_xfer;
  logic [DATA_W-1:0]   w_data;
  logic                w_last;

  // The output register can take a new beat when empty or draining this cycle.
  assign w_accept = ~r_m_valid | m_ready;

  // Rotate requests so the pointer's source sits at bit 0, then take the lowest set bit.
  assign w_dbl = {s_valid, s_valid};
  assign w_rot = w_dbl[r_ptr +: NUM_SRC];

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_off = 2'd0;
    w_any = 1'b1;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_any = 1'b0;
    endcase
  end

  always_comb begin
    w_grant = '0;
    w_sel   = r_ptr + w_off;
    if (r_state == ST_LOCKED) begin
      w_sel = r_lock_src;
      if (s_valid[r_lock_src]) w_grant[r_lock_src] = 1'b1;
    end else if (w_any) begin
      w_grant[w_sel] = 1'b1;
    end
  end

  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_sel == k[1:0]) begin
        w_data = s_data[k*DATA_W +: DATA_W];
        w_last = s_last[k];
      end
    end
  end

  assign s_ready = reset ? '0 : (w_grant & {NUM_SRC{w_accept}});
  assign w_xfer  = |(s_valid & s_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'd0;
      r_lock_src <= 2'd0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
      r_m_src    <= 2'd0;
    end else if (w_xfer) begin
      r_m_valid  <= 1'b1;
      r_m_data   <= w_data;
      r_m_last   <= w_last;
      r_m_src    <= w_sel;
      r_lock_src <= w_sel;
`ifdef AXIS_ARB_PACKET_LOCK_EN
      if (w_last) begin
        r_state <= ST_IDLE;
        r_ptr   <= w_sel + 2'd1;
      end else begin
        r_state <= ST_LOCKED;
      end
`else
      r_ptr <= w_sel + 2'd1;
`endif
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign m_src   = r_m_src;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter; lock scenario follows AXIS_ARB_PACKET_LOCK_EN.
module tb_axis_rr_arbiter;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        s_valid;
  logic [4*DATA_W-1:0] s_data;
  logic [3:0]        s_last;
  logic [3:0]        s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [1:0]        m_src;
  logic              m_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.DATA_W(DATA_W), .NUM_SRC(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_src   (m_src),
    .m_ready (m_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] d, input logic l);
    s_data[i*DATA_W +: DATA_W] = d;
    s_last[i] = l;
  endtask

  task automatic expect_beat(input string tag, input logic [1:0] src,
                             input logic [31:0] d, input logic l);
    check({tag, ".valid"}, m_valid, 1'b1);
    check({tag, ".src"},   m_src,   src);
    check({tag, ".data"},  m_data,  d);
    check({tag, ".last"},  m_last,  l);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 4'hF;
    s_data  = '0;
    s_last  = 4'h0;
    m_ready = 1'b1;

    // Reset state, with every source requesting during reset.
    #1;
    check("rst.s_ready", s_ready, 4'h0);
    tick();
    check("rst.m_valid", m_valid, 1'b0);
    check("rst.m_data",  m_data,  32'h0);
    check("rst.m_src",   m_src,   2'd0);
    check("rst.m_last",  m_last,  1'b0);

    // Single source 2.
    reset   = 1'b0;
    s_valid = 4'b0100;
    set_src(2, 32'hA5A5_0001, 1'b0);
    #1;
    check("single.s_ready", s_ready, 4'b0100);
    tick();
    s_valid = 4'h0;
    expect_beat("single", 2'd2, 32'hA5A5_0001, 1'b0);
    tick();
    check("single.drain", m_valid, 1'b0);
    #1;
    check("idle.s_ready", s_ready, 4'h0);

    // All four requesting continuously: 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 32'h100 + i, 1'b0);
    s_valid = 4'hF;
    tick(); expect_beat("rr0", 2'd0, 32'h100, 1'b0);
    tick(); expect_beat("rr1", 2'd1, 32'h101, 1'b0);
    tick(); expect_beat("rr2", 2'd2, 32'h102, 1'b0);
    tick(); expect_beat("rr3", 2'd3, 32'h103, 1'b0);
    tick(); expect_beat("rr4", 2'd0, 32'h100, 1'b0);
    tick(); expect_beat("rr5", 2'd1, 32'h101, 1'b0);

    // Backpressure for 3 cycles holding the source-1 beat; pointer now at 2.
    m_ready = 1'b0;
    #1;
    check("bp.s_ready0", s_ready, 4'h0);
    tick(); expect_beat("bp1", 2'd1, 32'h101, 1'b0); check("bp1.s_ready", s_ready, 4'h0);
    tick(); expect_beat("bp2", 2'd1, 32'h101, 1'b0); check("bp2.s_ready", s_ready, 4'h0);
    tick(); expect_beat("bp3", 2'd1, 32'h101, 1'b0); check("bp3.s_ready", s_ready, 4'h0);
    m_ready = 1'b1;
    #1;
    check("bp.release.s_ready", s_ready, 4'b0100);
    tick();
    s_valid = 4'h0;
    expect_beat("bp.next", 2'd2, 32'h102, 1'b0);
    tick();
    check("bp.drain", m_valid, 1'b0);

    // Source 1 sends a 3-beat packet while source 2 requests.
    do_reset();
    set_src(1, 32'h11, 1'b0);
    set_src(2, 32'h21, 1'b0);
    s_valid = 4'b0110;
`ifdef AXIS_ARB_PACKET_LOCK_EN
    tick(); expect_beat("lk1", 2'd1, 32'h11, 1'b0); set_src(1, 32'h12, 1'b0);
    tick(); expect_beat("lk2", 2'd1, 32'h12, 1'b0); set_src(1, 32'h13, 1'b1);
    tick(); expect_beat("lk3", 2'd1, 32'h13, 1'b1); s_valid = 4'b0100;
    tick(); expect_beat("lk4", 2'd2, 32'h21, 1'b0); s_valid = 4'b0000;
`else
    tick(); expect_beat("nl1", 2'd1, 32'h11, 1'b0); set_src(1, 32'h12, 1'b0);
    tick(); expect_beat("nl2", 2'd2, 32'h21, 1'b0); set_src(2, 32'h22, 1'b0);
    tick(); expect_beat("nl3", 2'd1, 32'h12, 1'b0); set_src(1, 32'h13, 1'b1);
    tick(); expect_beat("nl4", 2'd2, 32'h22, 1'b0); set_src(2, 32'h23, 1'b0);
    tick(); expect_beat("nl5", 2'd1, 32'h13, 1'b1); s_valid = 4'b0100;
    tick(); expect_beat("nl6", 2'd2, 32'h23, 1'b0); s_valid = 4'b0000;
`endif
    tick();
    check("pkt.drain", m_valid, 1'b0);

    // Reset mid-packet with a stalled beat, then contention between 0 and 2.
    set_src(1, 32'h31, 1'b0);
    s_valid = 4'b0010;
    tick();
    s_valid = 4'b0000;
    expect_beat("mid", 2'd1, 32'h31, 1'b0);
    m_ready = 1'b0;
    reset   = 1'b1;
    tick();
    check("mid.rst.valid", m_valid, 1'b0);
    check("mid.rst.src",   m_src,   2'd0);
    reset   = 1'b0;
    m_ready = 1'b1;
    set_src(0, 32'h40, 1'b1);
    set_src(2, 32'h42, 1'b1);
    s_valid = 4'b0101;
    #1;
    check("post.s_ready", s_ready, 4'b0001);
    tick();
    s_valid = 4'h0;
    expect_beat("post", 2'd0, 32'h40, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the data width of every stream.
REQ-002 SHALL have parameter NUM_SRC, default 4, the number of source streams; it is fixed at 4 in this revision.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_valid, input, 4 bits: per-source valid.
REQ-006 SHALL have port s_data, input, 4*DATA_W bits: source i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port s_last, input, 4 bits: per-source end-of-packet flag.
REQ-008 SHALL have port s_ready, output, 4 bits: per-source ready.
REQ-009 SHALL have port m_valid, output, 1 bit: registered output valid.
REQ-010 SHALL have port m_data, output, DATA_W bits: registered output data.
REQ-011 SHALL have port m_last, output, 1 bit: registered copy of the winning source's last flag.
REQ-012 SHALL have port m_src, output, 2 bits: index of the source that supplied the current m_data.
REQ-013 SHALL have port m_ready, input, 1 bit: downstream ready.

Function
REQ-014 SHALL define a source transfer as s_valid[i] & s_ready[i], and an output transfer as m_valid & m_ready.
REQ-015 SHALL drive s_ready[i] = grant[i] & (~m_valid | m_ready); this is combinational, and at most one bit is set per cycle.
REQ-016 SHALL, on a source transfer from source i, load m_data, m_last and m_src from source i and set m_valid on the next edge; latency is 1 cycle.
REQ-017 SHALL clear m_valid after an output transfer when no source transfer occurs in the same cycle.
REQ-018 SHALL keep m_valid at 1 when an output transfer and a source transfer occur in the same cycle, so full throughput is 1 beat per clock.
REQ-019 SHALL hold m_data, m_last and m_src stable while m_valid=1 and m_ready=0.
REQ-020 SHALL grant, when unlocked, the first requesting source found searching from pointer ptr upward, modulo 4.
REQ-021 SHALL set ptr to (i+1) mod 4 after each granted beat from source i, so wrap-around from source 3 goes to source 0.
REQ-022 SHALL assert no grant and no s_ready when no source is requesting; ptr is unchanged in that case.
REQ-023 SHALL NOT change the grant during a stalled cycle (m_valid=1, m_ready=0); a request that arrives during the stall is arbitrated once the output register can accept.
REQ-024 SHALL treat s_data and s_last of non-granted sources as don't-care.

Reset
REQ-025 SHALL, while reset=1 at posedge, set m_valid=0, m_data=0, m_last=0, m_src=0, ptr=0, state=IDLE, and drive s_ready=0 that cycle.
REQ-026 SHALL, if reset is asserted mid-packet or mid-stall, discard the held beat and the lock with no recovery.

Configuration
REQ-027 SHALL use macro AXIS_ARB_PACKET_LOCK_EN to select packet-lock mode.
REQ-028 SHALL, with AXIS_ARB_PACKET_LOCK_EN defined, implement state IDLE/LOCKED:
- IDLE -> LOCKED on a source transfer with s_last=0; the grant is then held on that source.
- LOCKED -> IDLE on a source transfer from the locked source with s_last=1.
- ptr advances only on that last-beat transfer.
- Other sources are not granted while LOCKED, even if the locked source deasserts s_valid.
REQ-029 SHALL, without AXIS_ARB_PACKET_LOCK_EN, re-arbitrate on every beat (REQ-021), ignore s_last for arbitration, and remain permanently in IDLE; m_last is still passed through.

Verification
REQ-030 SHALL cover single source: after reset, s_valid=4'b0100, data 0xA5A5_0001, m_ready=1 -> m_valid=1 next cycle, m_data=0xA5A5_0001, m_src=2.
REQ-031 SHALL cover all four sources requesting continuously with m_ready=1 -> m_src sequence 0,1,2,3,0,1 with no idle cycles.
REQ-032 SHALL cover backpressure: m_ready=0 for 3 cycles with a beat held -> s_ready=0, and m_data/m_src stable for 3 cycles; release -> next beat follows in the same cycle.
REQ-033 SHALL cover lock on: source 1 sends a 3-beat packet (last on beat 3) while source 2 requests -> m_src=1,1,1, then 2.
REQ-034 SHALL cover lock off, same stimulus as REQ-033 -> m_src=1,2,1,2,1.
REQ-035 SHALL cover reset asserted while m_valid=1 mid-packet -> next cycle m_valid=0, ptr=0, and source 0 wins the next contention.
